// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store.
// One transaction in flight; handles byte lanes, byte enables and load extension.
module mem_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic [31:0]           if_rdata,
  output logic                  if_valid,
  output logic                  if_stall,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [31:0]           d_wdata,
  input  logic [1:0]            d_size,
  input  logic                  d_signed,
  output logic [31:0]           d_rdata,
  output logic                  d_valid,
  output logic                  d_err,
  output logic                  d_stall,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_be,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_ack
);

  // state   | meaning
  // IDLE    | evaluate requests, pick a winner
  // IF_BUSY | fetch command issued, waiting for mem_ack
  // D_BUSY  | data command issued (or misaligned pass-through), waiting for mem_ack
  // DONE    | one-cycle valid pulse to the owner, requests ignored
  typedef enum logic [1:0] {IDLE, IF_BUSY, D_BUSY, DONE} state_t;

  localparam logic [3:0]            LIMIT      = STARVE_LIMIT[3:0];
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(3);

  state_t                state_q, state_d;
  logic [3:0]            streak_q, streak_d;
  logic                  grant_d, grant_if;
  logic                  own_d_q, first_q, err_q, sgn_q, we_q;
  logic [1:0]            lo_q, size_q;
  logic [3:0]            be_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q, rdata_q;
  logic                  d_req, mis;
  logic [3:0]            st_be;
  logic [31:0]           st_wdata;
  logic [7:0]            sel_b;
  logic [15:0]           sel_h;
  logic [31:0]           ld_ext;

  assign d_req = d_read | d_write;
  assign mis   = (d_size == 2'b01 && d_addr[0]) || (d_size[1] && d_addr[1:0] != 2'b00);

  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    grant_d  = 1'b0;
    grant_if = 1'b0;
    case (state_q)
      IDLE: begin
        if (d_req && (streak_q < LIMIT || !if_req)) grant_d = 1'b1;
        else if (if_req) grant_if = 1'b1;
        if (grant_d) state_d = D_BUSY;
        else if (grant_if) state_d = IF_BUSY;
        if (!if_req || grant_if) streak_d = 4'd0;
        else if (grant_d && streak_q < LIMIT) streak_d = streak_q + 4'd1;
      end
      IF_BUSY: if (mem_ack) state_d = DONE;
      D_BUSY:  if (err_q || mem_ack) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    st_be    = 4'b1111;
    st_wdata = d_wdata;
    case (d_size)
      2'b00: begin
        st_be    = 4'b0001 << d_addr[1:0];
        st_wdata = {4{d_wdata[7:0]}};
      end
      2'b01: begin
        st_be    = 4'b0011 << d_addr[1:0];
        st_wdata = {2{d_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Load lane select uses the address/size latched at grant time.
  always_comb begin
    case (lo_q)
      2'd1:    sel_b = mem_rdata[15:8];
      2'd2:    sel_b = mem_rdata[23:16];
      2'd3:    sel_b = mem_rdata[31:24];
      default: sel_b = mem_rdata[7:0];
    endcase
    sel_h = lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (size_q)
      2'b00:   ld_ext = {{24{sgn_q & sel_b[7]}}, sel_b};
      2'b01:   ld_ext = {{16{sgn_q & sel_h[15]}}, sel_h};
      default: ld_ext = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      streak_q <= 4'd0;
      own_d_q  <= 1'b0;
      first_q  <= 1'b0;
      err_q    <= 1'b0;
      sgn_q    <= 1'b0;
      we_q     <= 1'b0;
      lo_q     <= 2'b00;
      size_q   <= 2'b00;
      be_q     <= 4'b0000;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      first_q  <= 1'b0;
      if (grant_d) begin
        own_d_q <= 1'b1;
        first_q <= !mis;
        err_q   <= mis;
        sgn_q   <= d_signed;
        we_q    <= d_write;
        lo_q    <= d_addr[1:0];
        size_q  <= d_size;
        be_q    <= d_write ? st_be : 4'b1111;
        addr_q  <= d_addr & ALIGN_MASK;
        wdata_q <= d_write ? st_wdata : 32'd0;
      end else if (grant_if) begin
        own_d_q <= 1'b0;
        first_q <= 1'b1;
        err_q   <= 1'b0;
        we_q    <= 1'b0;
        be_q    <= 4'b1111;
        addr_q  <= if_addr & ALIGN_MASK;
        wdata_q <= 32'd0;
      end
      if (state_q == IF_BUSY && mem_ack) rdata_q <= mem_rdata;
      if (state_q == D_BUSY) begin
        if (err_q) rdata_q <= 32'd0;
        else if (mem_ack) rdata_q <= ld_ext;
      end
    end
  end

  assign mem_en    = first_q;
  assign mem_we    = we_q;
  assign mem_be    = be_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  assign if_valid = (state_q == DONE) && !own_d_q;
  assign d_valid  = (state_q == DONE) && own_d_q;
  assign d_err    = d_valid & err_q;
  assign if_rdata = if_valid ? rdata_q : 32'd0;
  assign d_rdata  = d_valid ? rdata_q : 32'd0;
  assign if_stall = if_req & ~if_valid;
  assign d_stall  = d_req & ~d_valid;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, contention, lane handling, misalignment, reset.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_valid, if_stall;
  logic        d_read = 1'b0, d_write = 1'b0, d_signed = 1'b0;
  logic [31:0] d_addr = '0, d_wdata = '0;
  logic [1:0]  d_size = 2'b10;
  logic [31:0] d_rdata;
  logic        d_valid, d_err, d_stall;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;

  int checks = 0;
  int failures = 0;

  mem_arbiter #(.ADDR_WIDTH(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_valid(if_valid), .if_stall(if_stall),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_size(d_size), .d_signed(d_signed), .d_rdata(d_rdata),
    .d_valid(d_valid), .d_err(d_err), .d_stall(d_stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  logic [1:0] got[10];
  logic [1:0] exp_order[10] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0};
  int gi;

  initial begin
    for (int i = 0; i < 10; i++) got[i] = 2'b11;
    #12;
    check("rst_mem_en", {31'd0, mem_en}, 32'd0);
    check("rst_valids", {30'd0, if_valid, d_valid}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // single fetch, ack two cycles after mem_en
    if_req = 1'b1; if_addr = 32'h0000_0103;
    tick();
    check("f_mem_en", {31'd0, mem_en}, 32'd1);
    check("f_mem_addr", mem_addr, 32'h0000_0100);
    check("f_mem_we", {31'd0, mem_we}, 32'd0);
    check("f_mem_be", {28'd0, mem_be}, 32'hF);
    check("f_stall", {31'd0, if_stall}, 32'd1);
    tick();
    check("f_mem_en_drop", {31'd0, mem_en}, 32'd0);
    check("f_addr_hold", mem_addr, 32'h0000_0100);
    tick();
    check("f_no_valid_yet", {31'd0, if_valid}, 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'h2408_0005;
    tick();
    mem_ack = 1'b0;
    check("f_valid", {31'd0, if_valid}, 32'd1);
    check("f_rdata", if_rdata, 32'h2408_0005);
    check("f_stall_low", {31'd0, if_stall}, 32'd0);
    if_req = 1'b0;
    tick();
    check("f_valid_pulse", {31'd0, if_valid}, 32'd0);

    // contention with ack held high: expect D,D,D,D,IF,D,D,D,D,IF
    if_req = 1'b1; if_addr = 32'h0000_1000;
    d_read = 1'b1; d_addr = 32'h0000_2000; d_size = 2'b10;
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    gi = 0;
    for (int c = 0; c < 80 && gi < 10; c++) begin
      tick();
      if (mem_en) begin
        got[gi] = (mem_addr == 32'h0000_2000) ? 2'd1 : 2'd0;
        gi++;
      end
    end
    check("grant_count", gi, 32'd10);
    for (int i = 0; i < 10; i++) check($sformatf("grant_order_%0d", i), {30'd0, got[i]}, {30'd0, exp_order[i]});
    if_req = 1'b0; d_read = 1'b0;
    tick();
    mem_ack = 1'b0;
    tick();
    tick();

    // signed byte load, then unsigned
    for (int s = 1; s >= 0; s--) begin
      d_read = 1'b1; d_addr = 32'h0000_0202; d_size = 2'b00; d_signed = s[0];
      tick();
      check("lb_mem_addr", mem_addr, 32'h0000_0200);
      check("lb_mem_be", {28'd0, mem_be}, 32'hF);
      mem_ack = 1'b1; mem_rdata = 32'h1180_7F22;
      tick();
      mem_ack = 1'b0;
      check("lb_valid", {31'd0, d_valid}, 32'd1);
      check("lb_rdata", d_rdata, s ? 32'hFFFF_FF80 : 32'h0000_0080);
      d_read = 1'b0;
      tick();
    end

    // signed half load from the upper half
    d_read = 1'b1; d_addr = 32'h0000_0302; d_size = 2'b01; d_signed = 1'b1;
    tick();
    mem_ack = 1'b1; mem_rdata = 32'h8001_1234;
    tick();
    mem_ack = 1'b0;
    check("lh_rdata", d_rdata, 32'hFFFF_8001);
    d_read = 1'b0;
    tick();

    // half store
    d_write = 1'b1; d_addr = 32'h0000_0046; d_size = 2'b01; d_wdata = 32'hDEAD_BEEF;
    tick();
    check("sh_mem_en", {31'd0, mem_en}, 32'd1);
    check("sh_mem_we", {31'd0, mem_we}, 32'd1);
    check("sh_mem_be", {28'd0, mem_be}, 32'hC);
    check("sh_mem_wdata", mem_wdata, 32'hBEEF_BEEF);
    check("sh_mem_addr", mem_addr, 32'h0000_0044);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("sh_valid", {31'd0, d_valid}, 32'd1);
    d_write = 1'b0;
    tick();

    // byte store in top lane
    d_write = 1'b1; d_addr = 32'h0000_0053; d_size = 2'b00; d_wdata = 32'h0000_00A5;
    tick();
    check("sb_mem_be", {28'd0, mem_be}, 32'h8);
    check("sb_mem_wdata", mem_wdata, 32'hA5A5_A5A5);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    d_write = 1'b0;
    tick();

    // misaligned word load
    d_read = 1'b1; d_addr = 32'h0000_0031; d_size = 2'b10; d_signed = 1'b0;
    tick();
    check("mis_no_mem_en", {31'd0, mem_en}, 32'd0);
    check("mis_no_valid_c1", {31'd0, d_valid}, 32'd0);
    tick();
    check("mis_valid", {31'd0, d_valid}, 32'd1);
    check("mis_err", {31'd0, d_err}, 32'd1);
    check("mis_rdata", d_rdata, 32'd0);
    d_read = 1'b0;
    tick();
    check("mis_err_pulse", {31'd0, d_err}, 32'd0);

    // reset while in D_BUSY, then a stray ack
    d_read = 1'b1; d_addr = 32'h0000_0010; d_size = 2'b10;
    tick();
    check("rb_mem_en", {31'd0, mem_en}, 32'd1);
    d_read = 1'b0;
    rst = 1'b0;
    #1;
    check("rb_mem_en_rst", {31'd0, mem_en}, 32'd0);
    check("rb_mem_addr_rst", mem_addr, 32'd0);
    check("rb_stalls", {30'd0, if_stall, d_stall}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    tick();
    mem_ack = 1'b0;
    check("rb_no_valid", {30'd0, if_valid, d_valid}, 32'd0);
    tick();
    check("rb_no_valid2", {30'd0, if_valid, d_valid}, 32'd0);
    if_req = 1'b1; if_addr = 32'h0000_0040;
    tick();
    check("rb_fetch_en", {31'd0, mem_en}, 32'd1);
    check("rb_fetch_addr", mem_addr, 32'h0000_0040);
    mem_ack = 1'b1; mem_rdata = 32'h0000_CAFE;
    tick();
    mem_ack = 1'b0;
    check("rb_fetch_valid", {31'd0, if_valid}, 32'd1);
    check("rb_fetch_rdata", if_rdata, 32'h0000_CAFE);
    if_req = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port unified memory between the instruction-fetch stage and the data (load/store) stage of the MIPS core.
- Arbitrates between the two requesters, sequences one outstanding memory transaction at a time, and stalls the losing stage.
- Performs byte/half/word lane selection, write byte-enables and load sign-extension, driven by the memRead/memWrite/memDataSize/memIsSigned control outputs.
- Sits between the pipeline stages and the memory wrapper.

Parameters:
ADDR_WIDTH, 32, byte-address width of if_addr, d_addr and mem_addr.
STARVE_LIMIT, 4, max consecutive data grants while fetch is pending before fetch is forced to win; legal range 1..15.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-low reset.
if_req  in  1  fetch request; held with if_addr stable while if_stall=1.
if_addr  in  ADDR_WIDTH  fetch byte address; bits [1:0] ignored (forced 00).
if_rdata  out  32  fetched instruction; valid only when if_valid=1.
if_valid  out  1  one-cycle completion pulse for fetch.
if_stall  out  1  if_req & ~if_valid.
d_read  in  1  load request (memRead).
d_write  in  1  store request (memWrite); wins if d_read is also high.
d_addr  in  ADDR_WIDTH  data byte address.
d_wdata  in  32  store data, right-justified.
d_size  in  2  00 byte, 01 half, 10 word, 11 treated as word (memDataSize).
d_signed  in  1  sign-extend loads when 1 (memIsSigned).
d_rdata  out  32  extended load data; valid when d_valid=1.
d_valid  out  1  one-cycle completion pulse for a load or store.
d_err  out  1  misalignment flag; pulses together with d_valid.
d_stall  out  1  (d_read|d_write) & ~d_valid.
mem_en  out  1  one-cycle command strobe to memory.
mem_we  out  1  write qualifier, valid with mem_en.
mem_addr  out  ADDR_WIDTH  word-aligned address; bits [1:0]=00.
mem_wdata  out  32  lane-replicated store data.
mem_be  out  4  byte enables; bit i covers bits [8i+7:8i], little-endian.
mem_rdata  in  32  read word; sampled on mem_ack.
mem_ack  in  1  transaction complete; honoured only in IF_BUSY or D_BUSY.

Behaviour:
- Reset (rst=0, async): state=IDLE, streak=0. All outputs 0; data outputs 0. A mem_ack arriving after reset is ignored.
- States:
  - IDLE: evaluates requests. Data wins if present and (streak<STARVE_LIMIT or if_req=0); otherwise fetch wins if if_req=1. Stays in IDLE if there is no request.
  - Grant (registered): next cycle enters IF_BUSY or D_BUSY with mem_en=1 for exactly that cycle. mem_addr, mem_we, mem_be and mem_wdata are latched and held until exit.
  - IF_BUSY / D_BUSY: wait for mem_ack. Ack is accepted in any BUSY cycle, including the mem_en cycle. On ack, capture mem_rdata and go to DONE.
  - DONE: pulses if_valid or d_valid (plus d_rdata/if_rdata) for one cycle, ignores all requests, then returns to IDLE.
- Minimum latency: request at cycle 0 -> mem_en at cycle 1 (ack at 1) -> valid at cycle 2 -> next grant evaluated at cycle 3.
- Streak counter:
  - +1 on each data grant made while if_req=1.
  - Cleared on a fetch grant, or in IDLE when if_req=0.
  - Saturates at STARVE_LIMIT.
- Store lanes:
  - Byte: mem_wdata={4{d_wdata[7:0]}}, mem_be=0001<<addr[1:0].
  - Half: mem_wdata={2{d_wdata[15:0]}}, mem_be=0011<<addr[1:0].
  - Word: mem_be=1111.
  - Reads drive mem_be=1111.
- Load extraction:
  - Select byte addr[1:0] or half addr[1], right-justify.
  - Zero- or sign-extend per d_signed; word loads pass through unchanged.
- Misalignment: half with addr[0]=1, or word with addr[1:0]!=00.
  - Granted as data, but no mem_en is issued; goes directly to DONE the next cycle.
  - d_valid=1, d_err=1, d_rdata=0, memory untouched.
  - Counts toward streak.
- Request held high after a valid pulse: treated as a new request at the next IDLE.
- Requester drops its request mid-transaction: the transaction still completes; the valid pulse is still issued.

Test Plan:
- Single fetch: if_req=1, if_addr=0x0000_0103, ack 2 cycles after mem_en, mem_rdata=0x2408_0005 -> mem_addr=0x100, mem_we=0, mem_be=1111, if_valid one cycle after ack with if_rdata=0x2408_0005, if_stall high until then.
- Contention/starvation (STARVE_LIMIT=4): if_req and d_read held continuously, ack same cycle -> grant order D,D,D,D,IF,D,D,D,D,IF.
- Signed byte load: d_addr=0x202, d_size=00, d_signed=1, mem_rdata=0x1180_7F22 -> d_rdata=0xFFFF_FF80; with d_signed=0 -> 0x0000_0080.
- Half store: d_write=1, d_addr=0x46, d_size=01, d_wdata=0xDEAD_BEEF -> mem_we=1, mem_be=1100, mem_wdata=0xBEEF_BEEF, mem_addr=0x44.
- Misaligned word load: d_addr=0x31, d_size=10 -> no mem_en, d_valid=d_err=1 two cycles after request, d_rdata=0.
- Reset mid-operation: drop rst in D_BUSY before ack, release, then pulse mem_ack -> all outputs 0, state IDLE, no valid pulse, next fetch proceeds normally.
